// File: rtl/spi_eeprom_pkg.sv
// Shared opcodes, status-register layout and FSM encoding for the SPI EEPROM responder.
package spi_eeprom_pkg;

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;

  localparam int STAT_WIP = 0;
  localparam int STAT_WEL = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_STATUS,
    ST_IGNORE
  } state_t;

  // WIP stays 0 because writes land in the buffer immediately.
  function automatic logic [7:0] status_byte(input logic wel);
    status_byte = 8'h00;
    status_byte[STAT_WIP] = 1'b0;
    status_byte[STAT_WEL] = wel;
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Synchronizes the SPI pins into clk and produces one-cycle sck/csn edge pulses.
module spi_slave_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic csn,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic csn_rise,
  output logic csn_fall,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] csn_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sck_d;
  logic                   csn_d;

  // csn resets to "selected" so a select held low across reset produces no
  // falling edge: a new transaction needs a genuine high-then-low on csn.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q  <= '0;
      csn_q  <= '0;
      mosi_q <= '0;
      sck_d  <= 1'b0;
      csn_d  <= 1'b0;
    end else begin
      sck_q  <= {sck_q[SYNC_STAGES-2:0], sck};
      csn_q  <= {csn_q[SYNC_STAGES-2:0], csn};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sck_d  <= sck_q[SYNC_STAGES-1];
      csn_d  <= csn_q[SYNC_STAGES-1];
    end
  end

  assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_d;
  assign sck_fall = ~sck_q[SYNC_STAGES-1] & sck_d;
  assign csn_rise = csn_q[SYNC_STAGES-1] & ~csn_d;
  assign csn_fall = ~csn_q[SYNC_STAGES-1] & csn_d;
  assign mosi_s   = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_eeprom_slave.sv
// SPI mode-0 responder emulating a 128x8 serial EEPROM in front of an external
// synchronous byte buffer (read data valid one clk after mem_addr).
module spi_eeprom_slave
  import spi_eeprom_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int PAGE_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              csn,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic              wel,
  output logic [2:0]        fsm_state
);

  logic       sck_rise;
  logic       sck_fall;
  logic       csn_rise;
  logic       csn_fall;
  logic       mosi_s;

  state_t     state;
  state_t     state_d;
  logic [2:0] bit_cnt;
  logic [6:0] rx;
  logic [7:0] rx_byte;
  logic [7:0] tx;
  logic [1:0] rd_pipe;
  logic       cmd_write;
  logic       byte_done;

  spi_slave_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .sck      (sck),
    .csn      (csn),
    .mosi     (mosi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .csn_rise (csn_rise),
    .csn_fall (csn_fall),
    .mosi_s   (mosi_s)
  );

  assign rx_byte   = {rx, mosi_s};
  assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state != ST_IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // A csn rise wins over any decode so a byte finishing on that same clk
  // still takes effect in the datapath but the FSM lands in IDLE.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (csn_fall) state_d = ST_CMD;
      ST_CMD: begin
        if (byte_done) begin
          case (rx_byte)
            OP_READ, OP_WRITE: state_d = ST_ADDR;
            OP_RDSR:           state_d = ST_STATUS;
            default:           state_d = ST_IGNORE;
          endcase
        end
      end
      ST_ADDR: if (byte_done) state_d = cmd_write ? ST_WR_DATA : ST_RD_DATA;
      default: state_d = state;
    endcase
    if (csn_rise) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wel       <= 1'b0;
      bit_cnt   <= '0;
      rx        <= '0;
      tx        <= '0;
      rd_pipe   <= '0;
      cmd_write <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      rd_pipe <= {rd_pipe[0], 1'b0};

      // Page-local increment runs the clk after the strobe so the strobe
      // carries the address the byte belongs to.
      if (mem_we) mem_addr[PAGE_W-1:0] <= mem_addr[PAGE_W-1:0] + PAGE_W'(1);

      if (rd_pipe[1]) tx <= mem_rdata;

      if (sck_rise && state != ST_IDLE) begin
        rx      <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (sck_fall && (state == ST_RD_DATA || state == ST_STATUS)) begin
        miso    <= tx[7];
        miso_oe <= 1'b1;
        tx      <= {tx[6:0], 1'b0};
      end

      if (byte_done) begin
        case (state)
          ST_CMD: begin
            cmd_write <= (rx_byte == OP_WRITE);
            if (rx_byte == OP_WREN) wel <= 1'b1;
            if (rx_byte == OP_WRDI) wel <= 1'b0;
            if (rx_byte == OP_RDSR) tx  <= status_byte(wel);
          end
          ST_ADDR: begin
            mem_addr <= rx_byte[ADDR_W-1:0];
            if (!cmd_write) rd_pipe[0] <= 1'b1;
          end
          ST_RD_DATA: begin
            mem_addr   <= mem_addr + ADDR_W'(1);
            rd_pipe[0] <= 1'b1;
          end
          ST_WR_DATA: begin
            if (wel) begin
              mem_we    <= 1'b1;
              mem_wdata <= rx_byte;
            end
          end
          ST_STATUS: tx <= status_byte(wel);
          default: ;
        endcase
      end

      if (csn_rise) begin
        bit_cnt <= '0;
        miso    <= 1'b0;
        miso_oe <= 1'b0;
        rd_pipe <= '0;
        if (state == ST_WR_DATA || (state == ST_ADDR && byte_done && cmd_write))
          wel <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_eeprom_slave.sv
// Bench for spi_eeprom_slave: SPI master driver, 128x8 registered RAM, and a
// transaction-level EEPROM model predicting read data, status and write strobes.
module tb_spi_eeprom_slave;

  localparam int DEPTH = 128;
  localparam logic [7:0] C_WRITE = 8'h02;
  localparam logic [7:0] C_READ  = 8'h03;
  localparam logic [7:0] C_WRDI  = 8'h04;
  localparam logic [7:0] C_RDSR  = 8'h05;
  localparam logic [7:0] C_WREN  = 8'h06;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       csn = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       wel;
  logic [2:0] fsm_state;

  always #5 clk = ~clk;

  spi_eeprom_slave dut (
    .clk       (clk),
    .rst       (rst),
    .sck       (sck),
    .csn       (csn),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .wel       (wel),
    .fsm_state (fsm_state)
  );

  // Buffer RAM, loaded from init_img while ram_load is high.
  logic [7:0] init_img[DEPTH];
  logic [7:0] ram[DEPTH];
  logic       ram_load = 1'b1;

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_img[i];
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  // Write monitor: every strobe cycle is captured; back-to-back strobe cycles are counted.
  logic [14:0] got_q[$];
  int          long_pulse = 0;
  logic        we_prev = 1'b0;

  always @(posedge clk) begin
    if (mem_we) got_q.push_back({mem_addr, mem_wdata});
    if (mem_we && we_prev) long_pulse++;
    we_prev <= mem_we;
  end

  // Reference model state.
  logic [7:0]  ref_mem[DEPTH];
  logic        ref_wel = 1'b0;
  logic [14:0] exp_q[$];
  logic [7:0]  wr_data[$];
  int          got_rd = 0;

  int n_tests = 0;
  int n_fail  = 0;
  int half    = 8;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits,
                          output logic [7:0] r, output logic [7:0] oe);
    r  = '0;
    oe = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      tick(half);
      r[i]  = miso;
      oe[i] = miso_oe;
      sck   = 1'b1;
      tick(half);
      sck   = 1'b0;
    end
  endtask

  task automatic cs_low();
    csn = 1'b0;
    tick(half);
  endtask

  task automatic cs_high();
    tick(half);
    csn = 1'b1;
    tick(8);
  endtask

  task automatic check_writes(input string tag);
    int n_got;
    n_got = got_q.size() - got_rd;
    check({tag, "_count"}, n_got, exp_q.size());
    for (int i = 0; i < n_got && i < exp_q.size(); i++)
      check(tag, got_q[got_rd + i], exp_q[i]);
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  task automatic do_cmd(input logic [7:0] op);
    logic [7:0] r, oe;
    half = $urandom_range(4, 10);
    cs_low();
    spi_bits(op, 8, r, oe);
    cs_high();
    if (op == C_WREN) ref_wel = 1'b1;
    if (op == C_WRDI) ref_wel = 1'b0;
    check("cmd_wel", wel, ref_wel);
    check("cmd_oe", oe, 8'h00);
  endtask

  task automatic do_write(input logic [7:0] addr);
    logic [7:0] r, oe;
    int a;
    half = $urandom_range(4, 10);
    cs_low();
    spi_bits(C_WRITE, 8, r, oe);
    spi_bits(addr, 8, r, oe);
    foreach (wr_data[i]) spi_bits(wr_data[i], 8, r, oe);
    cs_high();
    if (ref_wel) begin
      foreach (wr_data[i]) begin
        a = (int'(addr) & 'h70) | ((int'(addr) + i) & 'hF);
        ref_mem[a] = wr_data[i];
        exp_q.push_back({7'(a), wr_data[i]});
      end
    end
    ref_wel = 1'b0;
    check_writes("wr_strobe");
    check("wr_wel_after", wel, 1'b0);
  endtask

  task automatic do_read(input logic [7:0] addr, input int n);
    logic [7:0] r, oe;
    half = $urandom_range(4, 10);
    cs_low();
    spi_bits(C_READ, 8, r, oe);
    check("rd_cmd_oe", oe, 8'h00);
    spi_bits(addr, 8, r, oe);
    check("rd_addr_oe", oe, 8'h00);
    for (int i = 0; i < n; i++) begin
      spi_bits(8'($urandom), 8, r, oe);
      check("rd_data", r, ref_mem[(int'(addr) + i) % DEPTH]);
      check("rd_data_oe", oe, 8'hFF);
    end
    cs_high();
    check("rd_end_oe", miso_oe, 1'b0);
    check("rd_end_miso", miso, 1'b0);
  endtask

  task automatic do_rdsr(input int n);
    logic [7:0] r, oe;
    half = $urandom_range(4, 10);
    cs_low();
    spi_bits(C_RDSR, 8, r, oe);
    check("rdsr_cmd_oe", oe, 8'h00);
    for (int i = 0; i < n; i++) begin
      spi_bits(8'h00, 8, r, oe);
      check("rdsr_data", r, {6'b0, ref_wel, 1'b0});
      check("rdsr_oe", oe, 8'hFF);
    end
    cs_high();
    check("rdsr_end_oe", miso_oe, 1'b0);
  endtask

  initial begin
    #800us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r, oe;
    logic [7:0] addr;
    int         kind;

    for (int i = 0; i < DEPTH; i++) begin
      init_img[i] = 8'($urandom);
      ref_mem[i]  = init_img[i];
    end
    rst = 1'b1;
    tick(4);
    ram_load = 1'b0;
    rst      = 1'b0;
    tick(2);
    check("rst_miso", miso, 1'b0);
    check("rst_miso_oe", miso_oe, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 7'h00);
    check("rst_mem_wdata", mem_wdata, 8'h00);
    check("rst_wel", wel, 1'b0);

    // WREN then a two-byte write; wel drops when csn rises.
    do_cmd(C_WREN);
    wr_data = '{8'hA5, 8'h5A};
    do_write(8'h10);
    do_read(8'h10, 2);

    // Write without WREN is dropped.
    wr_data = '{8'hFF};
    do_write(8'h20);
    do_read(8'h20, 1);

    // Page wrap on write, array wrap on read.
    do_cmd(C_WREN);
    wr_data = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_write(8'h1E);
    do_read(8'h1E, 2);
    do_read(8'h10, 2);
    do_read(8'h7F, 2);

    // Status register follows wel.
    do_cmd(C_WREN);
    do_rdsr(2);
    do_cmd(C_WRDI);
    do_rdsr(2);

    // Partial data byte is discarded, but the completed address still clears wel.
    do_cmd(C_WREN);
    half = 6;
    cs_low();
    spi_bits(C_WRITE, 8, r, oe);
    spi_bits(8'h30, 8, r, oe);
    spi_bits(8'hC3, 5, r, oe);
    cs_high();
    ref_wel = 1'b0;
    check_writes("partial_strobe");
    check("partial_wel", wel, 1'b0);

    // csn rises on the same clk as the 8th data rising edge: byte still lands.
    do_cmd(C_WREN);
    half = 6;
    cs_low();
    spi_bits(C_WRITE, 8, r, oe);
    spi_bits(8'h40, 8, r, oe);
    spi_bits(8'h9C, 7, r, oe);
    mosi = 1'b0;
    tick(half);
    sck = 1'b1;
    csn = 1'b1;
    tick(half);
    sck = 1'b0;
    tick(8);
    ref_mem[8'h40] = 8'h9C;
    exp_q.push_back({7'h40, 8'h9C});
    ref_wel = 1'b0;
    check_writes("edge_strobe");
    check("edge_wel", wel, 1'b0);
    do_read(8'h40, 1);

    // Reset in the middle of a read data byte.
    do_cmd(C_WREN);
    half = 6;
    cs_low();
    spi_bits(C_READ, 8, r, oe);
    spi_bits(8'h10, 8, r, oe);
    spi_bits(8'h00, 3, r, oe);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    ref_wel = 1'b0;
    check("mid_rst_miso", miso, 1'b0);
    check("mid_rst_miso_oe", miso_oe, 1'b0);
    check("mid_rst_mem_we", mem_we, 1'b0);
    check("mid_rst_mem_addr", mem_addr, 7'h00);
    check("mid_rst_mem_wdata", mem_wdata, 8'h00);
    check("mid_rst_wel", wel, 1'b0);
    // csn never went high after reset, so this WREN must be ignored.
    tick(4);
    spi_bits(C_WREN, 8, r, oe);
    check("post_rst_oe", oe, 8'h00);
    cs_high();
    check("post_rst_wel", wel, 1'b0);
    do_read(8'h10, 2);

    // Randomized transactions against the model.
    for (int k = 0; k < 12; k++) begin
      kind = $urandom_range(0, 2);
      addr = 8'($urandom);
      if (kind == 0) begin
        if ($urandom_range(0, 3) != 0) do_cmd(C_WREN);
        wr_data.delete();
        for (int j = 0; j < int'($urandom_range(1, 4)); j++) wr_data.push_back(8'($urandom));
        do_write(addr);
      end else if (kind == 1) begin
        do_read(addr, $urandom_range(1, 3));
      end else begin
        if ($urandom_range(0, 1) != 0) do_cmd(C_WREN);
        do_rdsr($urandom_range(1, 2));
      end
    end

    check("we_pulse_width", long_pulse, 0);
    check("no_stray_writes", got_q.size() - got_rd, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
